mlp_sequencer: RTL and testbench

- Control FSM that time-multiplexes one shared MAC/activation neuron datapath across every hidden-layer and output-layer neuron of the MLP, one test sample at a time.
- Generates the weight, input and neuron addresses and the MAC strobes for each neuron.
- Tracks a running argmax over the output-layer results.
- Presents the predicted label with a ready strobe, then advances the test-sample counter until all samples are classified.

---
 rtl/mlp_sequencer_if.sv | 41 ++++
 rtl/mlp_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_mlp_sequencer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mlp_sequencer_if.sv
// mlp_sequencer_if: bundles the sequencer's control inputs and its address/strobe/result
// outputs so the sequencer, the shared neuron datapath and the sample host connect through one
// port.
//   master : sequencer side. It drives the addresses, the MAC/write strobes and the label.
//   slave  : datapath/host side. It drives clk_en, start, neuron_result and label_ack.
// The width parameters must match those of the mlp_sequencer instance that uses the interface.
interface mlp_sequencer_if #(
  parameter int unsigned N                          = 8,
  parameter int unsigned CLOG2_NUMBER_OF_INPUTS     = 6,
  parameter int unsigned CLOG2_SIZE_OF_HIDDEN_LAYER = 5,
  parameter int unsigned CLOG2_SIZE_OF_OUTPUT_LAYER = 4,
  parameter int unsigned CLOG2_NUMBER_OF_TEST_CASES = 10
);
  logic                                  clk_en;
  logic                                  start;
  logic signed [N-1:0]                   neuron_result;
  logic                                  label_ack;
  logic                                  layer_sel;
  logic [CLOG2_SIZE_OF_HIDDEN_LAYER-1:0] neuron_idx;
  logic [CLOG2_NUMBER_OF_INPUTS-1:0]     input_idx;
  logic [CLOG2_NUMBER_OF_TEST_CASES-1:0] sample_idx;
  logic                                  mac_en;
  logic                                  mac_first;
  logic                                  wr_en;
  logic                                  busy;
  logic [CLOG2_SIZE_OF_OUTPUT_LAYER-1:0] label;
  logic                                  ready;
  logic                                  all_done;

  modport master (
    input  clk_en, start, neuron_result, label_ack,
    output layer_sel, neuron_idx, input_idx, sample_idx, mac_en, mac_first, wr_en,
           busy, label, ready, all_done
  );

  modport slave (
    output clk_en, start, neuron_result, label_ack,
    input  layer_sel, neuron_idx, input_idx, sample_idx, mac_en, mac_first, wr_en,
           busy, label, ready, all_done
  );
endinterface

// File: rtl/mlp_sequencer.sv
// mlp_sequencer: control FSM that time-multiplexes one shared MAC/activation neuron across every
// hidden and output neuron of an MLP, one test sample at a time. It keeps a running argmax over
// the output-layer results and presents the winning class as the label.
//
// Ports:
//   clk, rst : rising-edge clock and asynchronous active-high reset.
//   bus      : mlp_sequencer_if master modport.
//     Inputs  : clk_en, start, neuron_result, label_ack.
//     Outputs : layer_sel, neuron_idx, input_idx, sample_idx, mac_en, mac_first, wr_en,
//               busy, label, ready, all_done.
//
// Optional feature: define MLP_SEQ_BACKPRESSURE_EN to hold DONE (ready=1) until label_ack.
// Without it, label_ack is ignored and ready is a one-cycle pulse.
module mlp_sequencer #(
  parameter int unsigned N                          = 8,
  parameter int unsigned NUMBER_OF_INPUTS           = 62,
  parameter int unsigned SIZE_OF_HIDDEN_LAYER       = 30,
  parameter int unsigned SIZE_OF_OUTPUT_LAYER       = 10,
  parameter int unsigned NUMBER_OF_TEST_CASES       = 750,
  parameter int unsigned CLOG2_NUMBER_OF_INPUTS     = 6,
  parameter int unsigned CLOG2_SIZE_OF_HIDDEN_LAYER = 5,
  parameter int unsigned CLOG2_SIZE_OF_OUTPUT_LAYER = 4,
  parameter int unsigned CLOG2_NUMBER_OF_TEST_CASES = 10
) (
  input  logic           clk,
  input  logic           rst,
  mlp_sequencer_if.master bus
);
  localparam int unsigned InW  = CLOG2_NUMBER_OF_INPUTS;
  localparam int unsigned HidW = CLOG2_SIZE_OF_HIDDEN_LAYER;
  localparam int unsigned OutW = CLOG2_SIZE_OF_OUTPUT_LAYER;
  localparam int unsigned SmpW = CLOG2_NUMBER_OF_TEST_CASES;

  localparam logic [InW-1:0]  LastHidIn  = InW'(NUMBER_OF_INPUTS - 1);
  localparam logic [InW-1:0]  LastOutIn  = InW'(SIZE_OF_HIDDEN_LAYER - 1);
  localparam logic [HidW-1:0] LastHidN   = HidW'(SIZE_OF_HIDDEN_LAYER - 1);
  localparam logic [HidW-1:0] LastOutN   = HidW'(SIZE_OF_OUTPUT_LAYER - 1);
  localparam logic [SmpW-1:0] LastSample = SmpW'(NUMBER_OF_TEST_CASES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StHidAcc,
    StHidWb,
    StOutAcc,
    StOutWb,
    StDone,
    StFinished
  } state_e;

  state_e              state_q, state_d;
  logic [HidW-1:0]     neuron_idx_q, neuron_idx_d;
  logic [InW-1:0]      input_idx_q, input_idx_d;
  logic [SmpW-1:0]     sample_idx_q, sample_idx_d;
  logic signed [N-1:0] max_q, max_d;
  logic [OutW-1:0]     label_q, label_d;
  logic                label_taken;

`ifdef MLP_SEQ_BACKPRESSURE_EN
  assign label_taken = bus.label_ack;
`else
  logic unused_label_ack;
  assign unused_label_ack = bus.label_ack;
  assign label_taken      = 1'b1;
`endif

  // State and counters. A low clk_en freezes everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      neuron_idx_q <= '0;
      input_idx_q  <= '0;
      sample_idx_q <= '0;
      max_q        <= '0;
      label_q      <= '0;
    end else if (bus.clk_en) begin
      state_q      <= state_d;
      neuron_idx_q <= neuron_idx_d;
      input_idx_q  <= input_idx_d;
      sample_idx_q <= sample_idx_d;
      max_q        <= max_d;
      label_q      <= label_d;
    end
  end

  // Next-state and counter sequencing.
  always_comb begin
    state_d      = state_q;
    neuron_idx_d = neuron_idx_q;
    input_idx_d  = input_idx_q;
    sample_idx_d = sample_idx_q;
    max_d        = max_q;
    label_d      = label_q;
    unique case (state_q)
      StIdle, StFinished: begin
        if (bus.start) begin
          state_d      = StHidAcc;
          neuron_idx_d = '0;
          input_idx_d  = '0;
          sample_idx_d = '0;
        end
      end
      StHidAcc: begin
        if (input_idx_q == LastHidIn) begin
          state_d     = StHidWb;
          input_idx_d = '0;
        end else begin
          input_idx_d = input_idx_q + InW'(1);
        end
      end
      StHidWb: begin
        input_idx_d = '0;
        if (neuron_idx_q == LastHidN) begin
          state_d      = StOutAcc;
          neuron_idx_d = '0;
        end else begin
          state_d      = StHidAcc;
          neuron_idx_d = neuron_idx_q + HidW'(1);
        end
      end
      StOutAcc: begin
        if (input_idx_q == LastOutIn) begin
          state_d     = StOutWb;
          input_idx_d = '0;
        end else begin
          input_idx_d = input_idx_q + InW'(1);
        end
      end
      StOutWb: begin
        // Neuron 0 seeds the argmax. Later neurons win only on a strictly greater result, so a
        // tie keeps the lower index.
        if (neuron_idx_q == '0) begin
          max_d   = bus.neuron_result;
          label_d = '0;
        end else if (bus.neuron_result > max_q) begin
          max_d   = bus.neuron_result;
          label_d = OutW'(neuron_idx_q);
        end
        if (neuron_idx_q == LastOutN) begin
          state_d = StDone;
        end else begin
          state_d      = StOutAcc;
          neuron_idx_d = neuron_idx_q + HidW'(1);
        end
      end
      StDone: begin
        if (label_taken) begin
          if (sample_idx_q == LastSample) begin
            state_d = StFinished;
          end else begin
            state_d      = StHidAcc;
            sample_idx_d = sample_idx_q + SmpW'(1);
            neuron_idx_d = '0;
            input_idx_d  = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the registered state. Only the strobes see clk_en, so a frozen
  // cycle never accumulates or writes.
  always_comb begin
    bus.layer_sel  = 1'b0;
    bus.mac_en     = 1'b0;
    bus.mac_first  = 1'b0;
    bus.wr_en      = 1'b0;
    bus.busy       = 1'b0;
    bus.ready      = 1'b0;
    bus.all_done   = 1'b0;
    bus.neuron_idx = neuron_idx_q;
    bus.input_idx  = input_idx_q;
    bus.sample_idx = sample_idx_q;
    bus.label      = label_q;
    unique case (state_q)
      StHidAcc: begin
        bus.busy      = 1'b1;
        bus.mac_en    = bus.clk_en;
        bus.mac_first = (input_idx_q == '0);
      end
      StHidWb: begin
        bus.busy  = 1'b1;
        bus.wr_en = bus.clk_en;
      end
      StOutAcc: begin
        bus.busy      = 1'b1;
        bus.layer_sel = 1'b1;
        bus.mac_en    = bus.clk_en;
        bus.mac_first = (input_idx_q == '0);
      end
      StOutWb: begin
        bus.busy      = 1'b1;
        bus.layer_sel = 1'b1;
      end
      StDone: begin
        bus.busy  = 1'b1;
        bus.ready = 1'b1;
      end
      StFinished: bus.all_done = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mlp_sequencer.sv
// Bench for mlp_sequencer in a small configuration (3 inputs, 2 hidden, 3 outputs, 2 samples).
// Per-cycle expectations come from the layer/neuron/fan-in timeline computed arithmetically.
// Labels come from a table or from a plain first-maximum search over the output results.
module tb_mlp_sequencer;
  localparam int unsigned N  = 8;
  localparam int unsigned NI = 3;
  localparam int unsigned NH = 2;
  localparam int unsigned NO = 3;
  localparam int unsigned NT = 2;
  localparam int unsigned WI = 2;
  localparam int unsigned WH = 2;
  localparam int unsigned WO = 2;
  localparam int unsigned WT = 1;
  localparam int HidCycles    = NH * (NI + 1);
  localparam int SampleCycles = NH * (NI + 1) + NO * (NH + 1) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mlp_sequencer_if #(
    .N                         (N),
    .CLOG2_NUMBER_OF_INPUTS    (WI),
    .CLOG2_SIZE_OF_HIDDEN_LAYER(WH),
    .CLOG2_SIZE_OF_OUTPUT_LAYER(WO),
    .CLOG2_NUMBER_OF_TEST_CASES(WT)
  ) bus ();

  mlp_sequencer #(
    .N                         (N),
    .NUMBER_OF_INPUTS          (NI),
    .SIZE_OF_HIDDEN_LAYER      (NH),
    .SIZE_OF_OUTPUT_LAYER      (NO),
    .NUMBER_OF_TEST_CASES      (NT),
    .CLOG2_NUMBER_OF_INPUTS    (WI),
    .CLOG2_SIZE_OF_HIDDEN_LAYER(WH),
    .CLOG2_SIZE_OF_OUTPUT_LAYER(WO),
    .CLOG2_NUMBER_OF_TEST_CASES(WT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [N-1:0]  r0;
    logic [N-1:0]  r1;
    logic [N-1:0]  r2;
    logic [WO-1:0] lbl;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int res_of(input vec_t v, input int n);
    case (n)
      0:       return int'($signed(v.r0));
      1:       return int'($signed(v.r1));
      default: return int'($signed(v.r2));
    endcase
  endfunction

  // Reference argmax: first index holding the largest signed value.
  function automatic int argmax(input vec_t v);
    int best = 0;
    for (int n = 1; n < int'(NO); n++) begin
      if (res_of(v, n) > res_of(v, best)) best = n;
    end
    return best;
  endfunction

  task automatic check_idle_zero(input string tag);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_ready"}, int'(bus.ready), 0);
    chk({tag, "_all_done"}, int'(bus.all_done), 0);
    chk({tag, "_mac_en"}, int'(bus.mac_en), 0);
    chk({tag, "_mac_first"}, int'(bus.mac_first), 0);
    chk({tag, "_wr_en"}, int'(bus.wr_en), 0);
    chk({tag, "_layer_sel"}, int'(bus.layer_sel), 0);
    chk({tag, "_neuron_idx"}, int'(bus.neuron_idx), 0);
    chk({tag, "_input_idx"}, int'(bus.input_idx), 0);
    chk({tag, "_sample_idx"}, int'(bus.sample_idx), 0);
    chk({tag, "_label"}, int'(bus.label), 0);
  endtask

  // Runs a full two-sample classification from IDLE or FINISHED.
  // freeze_c >= 0 stalls clk_en for three cycles at that cycle of sample 0.
  task automatic run_pair(input vec_t v0, input vec_t v1, input int freeze_c);
    vec_t v;
    int   n, i, acc, wb, done, out_layer, rel;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int s = 0; s < int'(NT); s++) begin
      v = (s == 0) ? v0 : v1;
      for (int c = 0; c < SampleCycles; c++) begin
        done = 0;
        n = 0;
        i = 0;
        out_layer = 0;
        if (c < HidCycles) begin
          n = c / (NI + 1);
          i = c % (NI + 1);
        end else if (c < SampleCycles - 1) begin
          rel = c - HidCycles;
          out_layer = 1;
          n = rel / (NH + 1);
          i = rel % (NH + 1);
        end else begin
          done = 1;
        end
        acc = (!done && i < (out_layer ? int'(NH) : int'(NI))) ? 1 : 0;
        wb  = (!done && !acc) ? 1 : 0;
        if (s == 0 && c == freeze_c) begin
          bus.clk_en = 1'b0;
          for (int k = 0; k < 3; k++) begin
            #1;
            chk("freeze_mac_en", int'(bus.mac_en), 0);
            chk("freeze_wr_en", int'(bus.wr_en), 0);
            chk("freeze_input_idx", int'(bus.input_idx), i);
            chk("freeze_neuron_idx", int'(bus.neuron_idx), n);
            @(negedge clk);
          end
          bus.clk_en = 1'b1;
        end
        bus.start         = 1'($urandom_range(0, 1));
        bus.neuron_result = (wb != 0 && out_layer != 0) ? N'(res_of(v, n)) : N'($urandom);
        bus.label_ack     = 1'($urandom_range(0, 1));
        #1;
        chk("busy", int'(bus.busy), 1);
        chk("all_done", int'(bus.all_done), 0);
        chk("sample_idx", int'(bus.sample_idx), s);
        chk("ready", int'(bus.ready), done);
        chk("mac_en", int'(bus.mac_en), acc);
        chk("wr_en", int'(bus.wr_en), (wb != 0 && out_layer == 0) ? 1 : 0);
        if (acc != 0) begin
          chk("layer_sel", int'(bus.layer_sel), out_layer);
          chk("acc_neuron_idx", int'(bus.neuron_idx), n);
          chk("input_idx", int'(bus.input_idx), i);
          chk("mac_first", int'(bus.mac_first), (i == 0) ? 1 : 0);
        end
        if (wb != 0) chk("wb_neuron_idx", int'(bus.neuron_idx), n);
        if (done != 0) begin
          chk("label", int'(bus.label), int'(v.lbl));
`ifdef MLP_SEQ_BACKPRESSURE_EN
          bus.label_ack = 1'b0;
          for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_ready", int'(bus.ready), 1);
            chk("bp_label", int'(bus.label), int'(v.lbl));
            chk("bp_sample_idx", int'(bus.sample_idx), s);
          end
          bus.label_ack = 1'b1;
`endif
        end
        @(negedge clk);
      end
    end
    bus.start = 1'b0;
    #1;
    chk("fin_all_done", int'(bus.all_done), 1);
    chk("fin_busy", int'(bus.busy), 0);
    chk("fin_ready", int'(bus.ready), 0);
    chk("fin_label", int'(bus.label), int'(v1.lbl));
    @(negedge clk);
    chk("fin_hold_all_done", int'(bus.all_done), 1);
    chk("fin_hold_mac_en", int'(bus.mac_en), 0);
  endtask

  vec_t tbl [8];
  vec_t ra, rb;

  initial begin
    // {r0, r1, r2, expected label}
    tbl[0] = {8'h05, 8'hFD, 8'h05, 2'd0};
    tbl[1] = {8'hF8, 8'hFE, 8'hFB, 2'd1};
    tbl[2] = {8'h01, 8'h02, 8'h03, 2'd2};
    tbl[3] = {8'h50, 8'h50, 8'h50, 2'd0};
    tbl[4] = {8'h7F, 8'h80, 8'h7F, 2'd0};
    tbl[5] = {8'h80, 8'h81, 8'h80, 2'd1};
    tbl[6] = {8'h00, 8'h00, 8'h01, 2'd2};
    tbl[7] = {8'hFF, 8'h00, 8'h00, 2'd1};

    bus.clk_en        = 1'b1;
    bus.start         = 1'b0;
    bus.label_ack     = 1'b0;
    bus.neuron_result = '0;
    rst               = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_idle_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_idle_zero("idle");

    for (int k = 0; k < 4; k++) begin
      run_pair(tbl[2*k], tbl[2*k+1], (k == 1) ? 5 : -1);
    end

    // Asynchronous reset in the middle of OUT_ACC.
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (HidCycles + 1) @(negedge clk);
    chk("pre_rst_layer_sel", int'(bus.layer_sel), 1);
    chk("pre_rst_mac_en", int'(bus.mac_en), 1);
    rst = 1'b1;
    #1;
    check_idle_zero("async_rst");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_hold_ready", int'(bus.ready), 0);
      chk("rst_hold_busy", int'(bus.busy), 0);
    end
    rst = 1'b0;
    @(negedge clk);
    check_idle_zero("post_rst");
    run_pair(tbl[1], tbl[0], -1);

    // Randomized result vectors against the reference argmax.
    for (int k = 0; k < 8; k++) begin
      ra.r0 = N'($urandom);
      ra.r1 = N'($urandom);
      ra.r2 = (k % 2 == 0) ? ra.r0 : N'($urandom);
      ra.lbl = WO'(argmax(ra));
      rb.r0 = N'($urandom);
      rb.r1 = N'($urandom);
      rb.r2 = N'($urandom);
      rb.lbl = WO'(argmax(rb));
      run_pair(ra, rb, (k == 3) ? 2 : -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
